sram_like_arbiter: RTL and testbench

Two-to-one arbiter sharing a single sram-like master port (toward the AXI bridge) between the instruction-fetch and data-memory sram-like interfaces of the CPU core. Grants one request at a time, holds the grant until the address handshake completes, and records the owner of every accepted transaction in an in-order tag FIFO so each m_data_ok returns to the correct requester. Its addr_ok/data_ok outputs feed the core's pipeline stall logic.

---
 rtl/sram_like_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like arbiter: inst/data share one master port, with an in-order tag FIFO routing responses.
// Define ARB_RR_EN for round-robin tie-breaking; the default build uses fixed data-over-inst priority.
module sram_like_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;
    typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_t;

    state_t           state, state_nx;
    src_t             hold_src, hold_src_nx, sel, head;
    src_t             tags [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full, push, pop;
`ifdef ARB_RR_EN
    src_t             rr_last;
`endif

    always_comb begin
        full = (count == CNT_W'(DEPTH));

        // A held grant is never re-arbitrated; sel also steers the master fields.
        sel = SRC_INST;
        if (state == HOLD) begin
            sel = hold_src;
        end else if (data_req && inst_req) begin
`ifdef ARB_RR_EN
            sel = (rr_last == SRC_INST) ? SRC_DATA : SRC_INST;
`else
            sel = SRC_DATA;
`endif
        end else if (data_req) begin
            sel = SRC_DATA;
        end

        m_req       = 1'b0;
        push        = 1'b0;
        state_nx    = state;
        hold_src_nx = hold_src;
        if (!rst && !full) begin
            if (state == HOLD) begin
                m_req = 1'b1;
                if (m_addr_ok) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end
            end else if (inst_req || data_req) begin
                m_req = 1'b1;
                if (m_addr_ok) begin
                    push = 1'b1;
                end else begin
                    state_nx    = HOLD;
                    hold_src_nx = sel;
                end
            end
        end

        inst_addr_ok = push && (sel == SRC_INST);
        data_addr_ok = push && (sel == SRC_DATA);

        m_wr    = (sel == SRC_DATA) ? data_wr    : inst_wr;
        m_size  = (sel == SRC_DATA) ? data_size  : inst_size;
        m_addr  = (sel == SRC_DATA) ? data_addr  : inst_addr;
        m_wdata = (sel == SRC_DATA) ? data_wdata : inst_wdata;

        // Pop reads the pre-edge head, so a same-cycle push is never answered early.
        head         = tags[rd_ptr];
        pop          = !rst && m_data_ok && (count != '0);
        inst_data_ok = pop && (head == SRC_INST);
        data_data_ok = pop && (head == SRC_DATA);
    end

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_src <= SRC_INST;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
`ifdef ARB_RR_EN
            rr_last  <= SRC_INST;
`endif
        end else begin
            state    <= state_nx;
            hold_src <= hold_src_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
`ifdef ARB_RR_EN
            if (push) rr_last <= sel;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= sel;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios then random traffic against a queue-based reference model.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    sram_like_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of owners (0=inst, 1=data), the source left waiting on a grant, last pushed source.
    int q[$];
    int pending = -1;
    int last    = 0;
    bit got_iaok, got_daok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller sets inputs shortly after a rising edge; outputs are checked then the model advances one cycle.
    task automatic tick();
        int  owner, ptag;
        bit  acc, pop;
        #1;
        owner = -1;
        if (!rst && q.size() < DEPTH) begin
            if (pending >= 0)               owner = pending;
            else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
                owner = (last == 0) ? 1 : 0;
`else
                owner = 1;
`endif
            end
            else if (data_req)              owner = 1;
            else if (inst_req)              owner = 0;
        end
        acc  = (owner >= 0) && m_addr_ok;
        pop  = !rst && m_data_ok && (q.size() > 0);
        ptag = pop ? q[0] : -1;

        chk("m_req",        {31'd0, m_req},        {31'd0, owner >= 0});
        chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, acc && owner == 0});
        chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, acc && owner == 1});
        chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, ptag == 0});
        chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, ptag == 1});
        chk("inst_rdata", inst_rdata, m_rdata);
        chk("data_rdata", data_rdata, m_rdata);
        if (owner >= 0) begin
            chk("m_addr",  m_addr,  owner == 1 ? data_addr  : inst_addr);
            chk("m_wdata", m_wdata, owner == 1 ? data_wdata : inst_wdata);
            chk("m_wr",    {31'd0, m_wr},   {31'd0, owner == 1 ? data_wr : inst_wr});
            chk("m_size",  {30'd0, m_size}, {30'd0, owner == 1 ? data_size : inst_size});
        end
        got_iaok = acc && owner == 0;
        got_daok = acc && owner == 1;

        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            pending = -1;
            last    = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(owner);
                pending = -1;
                last    = owner;
            end else if (owner >= 0) begin
                pending = owner;
            end
        end
    endtask

    task automatic set_inst(input logic wr, input logic [31:0] addr);
        inst_req = 1'b1; inst_wr = wr; inst_size = 2'd2; inst_addr = addr; inst_wdata = ~addr;
    endtask

    task automatic set_data(input logic wr, input logic [31:0] addr);
        data_req = 1'b1; data_wr = wr; data_size = 2'd2; data_addr = addr; data_wdata = addr ^ 32'h5A5A_5A5A;
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        @(posedge clk); #1;

        // Reset state and idle outputs
        tick();
        rst = 1'b0;
        tick();

        // Zero-cycle accept of a data read, response two cycles later
        set_data(1'b0, 32'h1FC0_0000);
        m_addr_ok = 1'b1;
        tick();
        data_req = 1'b0; m_addr_ok = 1'b0;
        tick();
        m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        tick();
        m_data_ok = 1'b0;

        // Both request, slave stalls 3 cycles: data held, inst follows
        set_inst(1'b0, 32'hBFC0_0100);
        set_data(1'b1, 32'h8000_0010);
        repeat (3) tick();
        m_addr_ok = 1'b1;
        tick();
        data_req = 1'b0;
        tick();
        inst_req = 1'b0; m_addr_ok = 1'b0;
        m_data_ok = 1'b1; m_rdata = 32'h1111_2222;
        repeat (2) tick();
        m_data_ok = 1'b0;

        // Fill to DEPTH with alternating sources, then backpressure
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) set_inst(1'b0, 32'h0000_1000 + i);
            else            set_data(1'b1, 32'h0000_2000 + i);
            m_addr_ok = 1'b1;
            tick();
            inst_req = 1'b0; data_req = 1'b0;
        end
        set_inst(1'b0, 32'h0000_3000);
        tick();
        m_data_ok = 1'b1; m_rdata = 32'hCAFE_0001;
        tick();
        m_data_ok = 1'b0;
        tick();
        inst_req = 1'b0; m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            m_rdata = 32'hCAFE_0010 + i;
            tick();
        end
        m_data_ok = 1'b0;

        // Push and pop in the same cycle at occupancy 2
        set_data(1'b0, 32'h0000_4000);
        m_addr_ok = 1'b1;
        tick();
        data_req = 1'b0;
        set_inst(1'b0, 32'h0000_4004);
        tick();
        inst_req = 1'b0;
        set_data(1'b0, 32'h0000_4008);
        m_data_ok = 1'b1; m_rdata = 32'h0BAD_F00D;
        tick();
        data_req = 1'b0; m_addr_ok = 1'b0;
        repeat (2) tick();
        m_data_ok = 1'b0;

        // Response with nothing outstanding, then reset while holding with 3 outstanding
        m_data_ok = 1'b1;
        tick();
        m_data_ok = 1'b0;
        m_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_data(1'b0, 32'h0000_5000 + 4 * i);
            tick();
            data_req = 1'b0;
        end
        m_addr_ok = 1'b0;
        set_inst(1'b0, 32'h0000_6000);
        tick();
        rst = 1'b1; inst_req = 1'b0;
        tick();
        rst = 1'b0;
        m_data_ok = 1'b1;
        tick();
        m_data_ok = 1'b0;
        set_data(1'b0, 32'h0000_7000);
        m_addr_ok = 1'b1;
        tick();
        data_req = 1'b0; m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        tick();
        m_data_ok = 1'b0;

        // Both held with immediate accepts: tie-break pattern
        set_inst(1'b0, 32'h0000_8000);
        set_data(1'b0, 32'h0000_9000);
        m_addr_ok = 1'b1;
        tick();
        m_data_ok = 1'b1;
        repeat (6) tick();
        inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
        repeat (2) tick();
        m_data_ok = 1'b0;

        // Random traffic with requesters holding until accepted
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (rst) begin
                inst_req = 1'b0;
                data_req = 1'b0;
            end else begin
                if (!inst_req && $urandom_range(0, 1) == 1) begin
                    inst_req = 1'b1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
                    inst_addr = $urandom; inst_wdata = $urandom;
                end
                if (!data_req && $urandom_range(0, 1) == 1) begin
                    data_req = 1'b1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
                    data_addr = $urandom; data_wdata = $urandom;
                end
            end
            m_addr_ok = 1'($urandom);
            m_data_ok = ($urandom_range(0, 2) == 0);
            m_rdata   = $urandom;
            tick();
            if (got_iaok) inst_req = 1'b0;
            if (got_daok) data_req = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
